// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin memory-bus arbiter with a dead TURN cycle between owners; optional hold watchdog via ARB_TIMEOUT_EN
module bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   nReset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*16-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]     req_nRead,
  input  logic [NUM_REQ-1:0]     req_nWrite,
  input  logic [NUM_REQ*256-1:0] req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [15:0]            bus_addr,
  output logic                   bus_nRead,
  output logic                   bus_nWrite,
  output logic [255:0]           bus_wdata,
  output logic                   bus_drive_en,
  output logic                   busy,
  output logic                   timeout_err
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
  state_t state, state_d;
  logic [IW-1:0] ptr, ptr_d, owner, owner_d, win, idx;
  logic [NUM_REQ-1:0] avail, gnt_d;
  logic found, hold, expire, own_d;
  logic [15:0] addr_d;
  logic [255:0] wdata_d;
  logic nrd_d, nwr_d, de_d;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("bus_arbiter: parameter out of range");
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt, cnt_d;
  logic [NUM_REQ-1:0] mask, mask_d;
  assign expire = state == OWN && req[owner] && cnt == 8'(TIMEOUT);
  assign avail = req & ~mask;
  // Hold counter, arbitration mask and watchdog pulse; a mask bit clears once its req is seen low
  always_comb begin
    cnt_d = state_d == OWN ? (state == OWN ? cnt + 8'd1 : 8'd1) : 8'd0;
    mask_d = (mask & req) | (expire ? {{(NUM_REQ-1){1'b0}}, 1'b1} << owner : '0);
  end
  // Watchdog state registers
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      cnt <= '0;
      mask <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt <= cnt_d;
      mask <= mask_d;
      timeout_err <= expire;
    end
`else
  assign expire = 1'b0;
  assign avail = req;
  assign timeout_err = 1'b0;
`endif

  assign hold = req[owner] && !expire;

  // Round-robin search: first available requester at or above ptr, wrapping
  always_comb begin
    win = ptr;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % NUM_REQ);
      if (avail[idx]) win = idx;
    end
    found = |avail;
  end

  // State register
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
    end else begin
      state <= state_d;
      ptr <= ptr_d;
      owner <= owner_d;
    end

  // Next state: owner keeps the bus while requesting; IDLE and TURN both grant any available requester
  always_comb begin
    state_d = state == OWN ? (hold ? OWN : TURN) : (found ? OWN : IDLE);
    owner_d = state != OWN && found ? win : owner;
    ptr_d = state != OWN && found ? (win == IW'(NUM_REQ - 1) ? '0 : win + 1'b1) : ptr;
  end

  // Next outputs: owner's inputs pass through one register stage, otherwise the bus is parked idle
  always_comb begin
    own_d = state_d == OWN;
    addr_d = '0;
    wdata_d = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (owner_d == IW'(i)) begin
        addr_d = req_addr[i*16 +: 16];
        wdata_d = req_wdata[i*256 +: 256];
      end
    gnt_d = own_d ? {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_d : '0;
    addr_d = own_d ? addr_d : 16'h0000;
    wdata_d = own_d ? wdata_d : '0;
    nrd_d = own_d ? req_nRead[owner_d] : 1'b1;
    nwr_d = own_d ? req_nWrite[owner_d] : 1'b1;
    de_d = own_d && !req_nWrite[owner_d];
  end

  // Output registers
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      gnt <= '0;
      bus_addr <= 16'h0000;
      bus_nRead <= 1'b1;
      bus_nWrite <= 1'b1;
      bus_wdata <= '0;
      bus_drive_en <= 1'b0;
      busy <= 1'b0;
    end else begin
      gnt <= gnt_d;
      bus_addr <= addr_d;
      bus_nRead <= nrd_d;
      bus_nWrite <= nwr_d;
      bus_wdata <= wdata_d;
      bus_drive_en <= de_d;
      busy <= own_d;
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: table-driven and sequence checks of bus_arbiter (NUM_REQ=4, TIMEOUT=8)
module tb_bus_arbiter;
  logic clk = 1'b0, nReset;
  logic [3:0] req, req_nRead, req_nWrite, gnt;
  logic [63:0] req_addr;
  logic [1023:0] req_wdata;
  logic [15:0] bus_addr;
  logic bus_nRead, bus_nWrite, bus_drive_en, busy, timeout_err;
  logic [255:0] bus_wdata;
  logic [33:0] act, idl;
  int checks = 0, errors = 0;
  localparam logic [3:0] D_NRD = 4'b0100, D_NWR = 4'b1011;

  typedef struct {
    logic [3:0] req, nrd, nwr;
    logic [33:0] exp;
  } vec_t;
  vec_t v[16];

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_REQ(4), .TIMEOUT(8)) dut (
    .clk(clk), .nReset(nReset), .req(req), .req_addr(req_addr),
    .req_nRead(req_nRead), .req_nWrite(req_nWrite), .req_wdata(req_wdata),
    .gnt(gnt), .bus_addr(bus_addr), .bus_nRead(bus_nRead), .bus_nWrite(bus_nWrite),
    .bus_wdata(bus_wdata), .bus_drive_en(bus_drive_en), .busy(busy), .timeout_err(timeout_err)
  );

  assign act = {gnt, bus_addr, bus_nRead, bus_nWrite, bus_drive_en, busy, timeout_err,
                bus_wdata[7:0], |bus_wdata[255:8]};

  function automatic logic [33:0] mk(logic [3:0] g, logic [15:0] a, logic r, logic w, logic d,
                                     logic b, logic [7:0] wd);
    return {g, a, r, w, d, b, 1'b0, wd, 1'b0};
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    nReset = 1'b0;
    #2;
    nReset = 1'b1;
  endtask

  initial begin
    idl = mk(4'b0000, 16'h0000, 1, 1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      req_addr[i*16 +: 16] = 16'h1000 * 16'(i + 1);
      req_wdata[i*256 +: 256] = 256'hA3 + 256'(i);
    end
    v[0]  = '{4'b0001, D_NRD, D_NWR, mk(4'b0001, 16'h1000, 0, 1, 0, 1, 8'hA3)};
    v[1]  = '{4'b0001, D_NRD, D_NWR, mk(4'b0001, 16'h1000, 0, 1, 0, 1, 8'hA3)};
    v[2]  = '{4'b0000, D_NRD, D_NWR, idl};
    v[3]  = '{4'b0000, D_NRD, D_NWR, idl};
    v[4]  = '{4'b1111, D_NRD, D_NWR, mk(4'b0010, 16'h2000, 0, 1, 0, 1, 8'hA4)};
    v[5]  = '{4'b1111, D_NRD, D_NWR, mk(4'b0010, 16'h2000, 0, 1, 0, 1, 8'hA4)};
    v[6]  = '{4'b1101, D_NRD, D_NWR, idl};
    v[7]  = '{4'b1111, D_NRD, D_NWR, mk(4'b0100, 16'h3000, 1, 0, 1, 1, 8'hA5)};
    v[8]  = '{4'b1111, D_NRD, D_NWR, mk(4'b0100, 16'h3000, 1, 0, 1, 1, 8'hA5)};
    v[9]  = '{4'b1011, D_NRD, D_NWR, idl};
    v[10] = '{4'b1111, D_NRD, D_NWR, mk(4'b1000, 16'h4000, 0, 1, 0, 1, 8'hA6)};
    v[11] = '{4'b0111, D_NRD, D_NWR, idl};
    v[12] = '{4'b0111, D_NRD, D_NWR, mk(4'b0001, 16'h1000, 0, 1, 0, 1, 8'hA3)};
    v[13] = '{4'b0111, 4'b0100, 4'b1010, mk(4'b0001, 16'h1000, 0, 0, 1, 1, 8'hA3)};
    v[14] = '{4'b0000, D_NRD, D_NWR, idl};
    v[15] = '{4'b0000, D_NRD, D_NWR, idl};

    nReset = 1'b0;
    req = '0;
    req_nRead = D_NRD;
    req_nWrite = D_NWR;
    #12;
    chk("reset", act, idl);
    @(negedge clk);
    nReset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      req = v[i].req;
      req_nRead = v[i].nrd;
      req_nWrite = v[i].nwr;
      tick;
      chk($sformatf("vec%0d", i), act, v[i].exp);
    end
    req_nRead = D_NRD;
    req_nWrite = D_NWR;

    pulse_reset;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick;
      chk($sformatf("rr_gnt%0d", g), gnt, 4'b0001 << (g % 4));
      tick;
      tick;
      chk($sformatf("rr_hold%0d", g), {gnt, busy}, {4'b0001 << (g % 4), 1'b1});
      req = 4'b1111 & ~(4'b0001 << (g % 4));
      tick;
      chk($sformatf("rr_turn%0d", g), {gnt, busy}, 5'b0);
      req = 4'b1111;
    end

    pulse_reset;
    req = 4'b0100;
    tick;
    chk("rst_own", gnt, 4'b0100);
    #3;
    nReset = 1'b0;
    #1;
    chk("rst_async", act, idl);
    #2;
    req = 4'b1100;
    nReset = 1'b1;
    tick;
    chk("rst_regrant", act, mk(4'b0100, 16'h3000, 1, 0, 1, 1, 8'hA5));

`ifdef ARB_TIMEOUT_EN
    pulse_reset;
    req = 4'b1010;
    tick;
    chk("to_gnt1", {gnt, timeout_err}, {4'b0010, 1'b0});
    for (int c = 0; c < 7; c++) begin
      tick;
      chk($sformatf("to_hold%0d", c), {gnt, timeout_err}, {4'b0010, 1'b0});
    end
    tick;
    chk("to_pulse", {gnt, timeout_err, busy}, {4'b0000, 1'b1, 1'b0});
    tick;
    chk("to_next", {gnt, timeout_err}, {4'b1000, 1'b0});
    req = 4'b0010;
    tick;
    chk("to_turn", gnt, 4'b0000);
    tick;
    chk("to_masked", {gnt, busy}, 5'b0);
    req = 4'b0000;
    tick;
    req = 4'b0010;
    tick;
    chk("to_unmask", gnt, 4'b0010);
    for (int c = 0; c < 7; c++) tick;
    req = 4'b0000;
    tick;
    chk("to_edge_release", {gnt, timeout_err}, 5'b0);
    req = 4'b0010;
    tick;
    chk("to_edge_nomask", {gnt, timeout_err}, {4'b0010, 1'b0});
`else
    begin
      int bad;
      bad = 0;
      pulse_reset;
      req = 4'b0001;
      tick;
      chk("long_gnt", gnt, 4'b0001);
      for (int c = 0; c < 1000; c++) begin
        tick;
        if (gnt !== 4'b0001 || timeout_err !== 1'b0) bad++;
      end
      chk("long_hold_bad_cycles", bad, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
